condlogic_it: RTL and testbench
===============================

Name: condlogic_it

Overview:
- Parametrised successor to the multicycle conditional-execution unit.
- Holds the architectural condition flags and evaluates each instruction's condition field against them.
- Gates register, memory and PC writes on the outcome.
- Adds IT-block predication: an IT instruction supplies a base condition, a then/else mask and a length (1..IT_MAX). The following instructions then execute under those conditions instead of their own Cond field.
- Sits between the main control FSM and the datapath.

Parameters:
- IT_MAX, 4: maximum number of instructions covered by one IT block (1..8).
- LEN_W, $clog2(IT_MAX+1): width of ITLen and ITRemaining.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- Cond  in  4  condition field of the current instruction.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- FlagW  in  2  [1]=write N,Z; [0]=write C,V.
- PCS  in  1  instruction writes PC (branch / PC-destination).
- NextPC  in  1  FSM fetch-stage PC update.
- RegW  in  1  FSM register write request.
- MemW  in  1  FSM memory write request.
- InstrDone  in  1  one-cycle pulse in the final state of each instruction.
- ITStart  in  1  the completing instruction is an IT (sampled with InstrDone).
- ITCond  in  4  IT base condition.
- ITThen  in  IT_MAX  bit i=1 means slot i uses ITCond; 0 means inverted condition (ITCond with LSB flipped).
- ITLen  in  LEN_W  number of predicated instructions.
- PCWrite  out  1  PC write enable.
- RegWrite  out  1  register-file write enable.
- MemWrite  out  1  data-memory write enable.
- Flags  out  4  current {N,Z,C,V}.
- InITBlock  out  1  FSM is in state ACTIVE.
- ITRemaining  out  LEN_W  predicated instructions still to complete.

Behaviour:
- Reset, asynchronous: Flags=0, CondExFl=0, state IDLE, slot index=0, ITRemaining=0, stored IT fields=0. All outputs therefore read 0, except PCWrite, which follows NextPC.
- Effective condition:
  - IDLE: Cond.
  - ACTIVE: ITCond_r if ITThen_r[idx] is set, otherwise ITCond_r^4'b0001.
  - Cond is ignored while ACTIVE.
- CondEx: combinational check of the effective condition against Flags, using standard ARM codes 0000..1110. Code 1111 evaluates true.
- FlagWrite = FlagW & {2{CondEx}}. Flags[3:2] load ALUFlags[3:2] when FlagWrite[1]; Flags[1:0] load ALUFlags[1:0] when FlagWrite[0]. Update takes effect on the next edge.
- CondExFl <= CondEx every cycle, giving one-cycle latency.
- Write enables:
  - PCWrite = NextPC | (PCS & CondExFl).
  - RegWrite = RegW & CondExFl.
  - MemWrite = MemW & CondExFl.
- FSM IDLE -> ACTIVE: on InstrDone & ITStart with 1<=ITLen<=IT_MAX. Latch ITCond/ITThen/ITLen; idx=0; ITRemaining=ITLen. The IT instruction itself is unconditional.
- FSM in ACTIVE, on InstrDone:
  - idx++ and ITRemaining--.
  - Return to IDLE when ITRemaining reaches 0.
- Taken-branch abort: if InstrDone & PCS & CondExFl while ACTIVE, go to IDLE immediately and clear ITRemaining. This takes priority over the decrement.
- Invalid starts are ignored and the FSM stays IDLE:
  - ITStart without InstrDone.
  - ITLen=0.
  - ITLen>IT_MAX.
- ITStart while ACTIVE is ignored; the predicated instruction completes normally.
- ITCond=1110 (AL) with any else slot: the else slot evaluates code 1111, i.e. it executes.
- Reset mid-block: returns to IDLE at once and discards the stored IT state.

Optional Feature:
- Macro: CONDLOGIC_ITERR_EN.
- Defined: an extra output ITErr (1 bit, reset 0). It is sticky-set on any ignored ITStart (invalid length, or ITStart while ACTIVE) and on an AL base with a cleared ITThen bit inside ITLen. Only reset clears it.
- Undefined: the port is absent; the same cases are silently ignored as described above.

Decomposition:
- Package condlogic_pkg holds:
  - condition-code localparams EQ..AL;
  - flag bit indices N=3, Z=2, C=1, V=0;
  - FSM state typedef {IDLE, ACTIVE}.
- The existing condcheck is reused unchanged for condition evaluation.
- One new sub-module, it_tracker, owns the FSM, idx, ITRemaining, latched IT fields and the effective-condition mux.

Test Plan:
- Flags=0100 (Z), Cond=0000 (EQ), RegW=1 -> RegWrite=1 one cycle later. Cond=0001 (NE) -> RegWrite stays 0.
- FlagW=10, Cond=1110, ALUFlags=1010 -> only N,Z update: Flags=10xx, with C,V keeping their old values. Repeat with Cond false -> Flags unchanged.
- Z=1; IT: ITCond=0000, ITThen=0101, ITLen=3, with InstrDone -> InITBlock=1, ITRemaining=3. Then three InstrDone pulses with RegW=1 and Cond=1110 give RegWrite 1,0,1 and ITRemaining 2,1,0, then InITBlock=0.
- IT block of length 4 with taken branch (PCS=1, condition true) in slot 1 -> PCWrite=1. On that InstrDone, InITBlock=0 and ITRemaining=0; the next instruction uses its own Cond.
- ITLen=0, and separately ITLen=5 with IT_MAX=4 -> stays IDLE; ITErr=1 when CONDLOGIC_ITERR_EN is defined.
- Assert reset asynchronously mid-block (ITRemaining=2) -> all state cleared before the next edge; Flags=0, InITBlock=0.

Source files
------------

// File: rtl/condlogic_pkg.sv
// Shared definitions for the conditional-execution unit with IT-block predication.
package condlogic_pkg;

  // ARM condition codes. Code 4'b1111 is not named and evaluates true.
  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] NE = 4'b0001;
  localparam logic [3:0] CS = 4'b0010;
  localparam logic [3:0] CC = 4'b0011;
  localparam logic [3:0] MI = 4'b0100;
  localparam logic [3:0] PL = 4'b0101;
  localparam logic [3:0] VS = 4'b0110;
  localparam logic [3:0] VC = 4'b0111;
  localparam logic [3:0] HI = 4'b1000;
  localparam logic [3:0] LS = 4'b1001;
  localparam logic [3:0] GE = 4'b1010;
  localparam logic [3:0] LT = 4'b1011;
  localparam logic [3:0] GT = 4'b1100;
  localparam logic [3:0] LE = 4'b1101;
  localparam logic [3:0] AL = 4'b1110;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int unsigned N = 3;
  localparam int unsigned Z = 2;
  localparam int unsigned C = 1;
  localparam int unsigned V = 0;

  typedef enum logic {IDLE, ACTIVE} it_state_e;

endpackage

// File: rtl/condcheck.sv
// Evaluates a 4-bit ARM condition code against the {N,Z,C,V} flags.
module condcheck
  import condlogic_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic neg, zero, carry, ovf, ge;

  // Pure decode of the condition field.
  always_comb begin
    neg   = Flags[N];
    zero  = Flags[Z];
    carry = Flags[C];
    ovf   = Flags[V];
    ge    = (neg == ovf);
    case (Cond)
      EQ:      CondEx = zero;
      NE:      CondEx = ~zero;
      CS:      CondEx = carry;
      CC:      CondEx = ~carry;
      MI:      CondEx = neg;
      PL:      CondEx = ~neg;
      VS:      CondEx = ovf;
      VC:      CondEx = ~ovf;
      HI:      CondEx = carry & ~zero;
      LS:      CondEx = ~(carry & ~zero);
      GE:      CondEx = ge;
      LT:      CondEx = ~ge;
      GT:      CondEx = ~zero & ge;
      LE:      CondEx = ~(~zero & ge);
      default: CondEx = 1'b1;  // AL and 4'b1111
    endcase
  end

endmodule

// File: rtl/it_tracker.sv
// IT-block tracker: FSM, slot index, remaining count, latched IT fields and
// the effective-condition mux. Optional sticky ITErr when CONDLOGIC_ITERR_EN is defined.
module it_tracker
  import condlogic_pkg::*;
#(
  parameter int unsigned IT_MAX = 4,
  parameter int unsigned LEN_W  = $clog2(IT_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        Cond,
  input  logic              InstrDone,
  input  logic              ITStart,
  input  logic [3:0]        ITCond,
  input  logic [IT_MAX-1:0] ITThen,
  input  logic [LEN_W-1:0]  ITLen,
  input  logic              PCS,
  input  logic              CondExFl,
  output logic [3:0]        EffCond,
  output logic              InITBlock,
  output logic [LEN_W-1:0]  ITRemaining
`ifdef CONDLOGIC_ITERR_EN
  ,
  output logic              ITErr
`endif
);

  localparam int unsigned IdxW = (IT_MAX > 1) ? $clog2(IT_MAX) : 1;

  it_state_e         state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [3:0]        it_cond_q, it_cond_d;
  logic [IT_MAX-1:0] it_then_q, it_then_d;
  logic              len_ok;

  // Length is held only as the remaining count; it is all the block needs afterwards.
  always_comb len_ok = (ITLen != '0) && (ITLen <= LEN_W'(IT_MAX));

  // Next-state logic: start, per-instruction advance and taken-branch abort.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    it_cond_d = it_cond_q;
    it_then_d = it_then_q;
    case (state_q)
      IDLE: begin
        if (InstrDone && ITStart && len_ok) begin
          state_d   = ACTIVE;
          it_cond_d = ITCond;
          it_then_d = ITThen;
          idx_d     = '0;
          rem_d     = ITLen;
        end
      end
      ACTIVE: begin
        if (InstrDone) begin
          if (PCS && CondExFl) begin
            // Taken branch leaves the block; remaining slots are dropped.
            state_d = IDLE;
            idx_d   = '0;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - LEN_W'(1);
            idx_d = idx_q + IdxW'(1);
            if (rem_q == LEN_W'(1)) begin
              state_d = IDLE;
              idx_d   = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched IT fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      it_cond_q <= '0;
      it_then_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      it_cond_q <= it_cond_d;
      it_then_q <= it_then_d;
    end
  end

  // Effective condition; an else slot flips the LSB, so AL becomes 4'b1111 (true).
  always_comb begin
    EffCond = Cond;
    if (state_q == ACTIVE) begin
      EffCond = it_then_q[idx_q] ? it_cond_q : (it_cond_q ^ 4'b0001);
    end
  end

  assign InITBlock   = (state_q == ACTIVE);
  assign ITRemaining = rem_q;

`ifdef CONDLOGIC_ITERR_EN
  logic              err_q;
  logic              err_set;
  logic [IT_MAX-1:0] len_mask;

  // Flags ignored starts and AL blocks that contain an else slot.
  always_comb begin
    for (int i = 0; i < IT_MAX; i++) begin
      len_mask[i] = (LEN_W'(i) < ITLen);
    end
    err_set = 1'b0;
    if (InstrDone && ITStart) begin
      if (state_q == ACTIVE || !len_ok) begin
        err_set = 1'b1;
      end else if (ITCond == AL && |(~ITThen & len_mask)) begin
        err_set = 1'b1;
      end
    end
  end

  // Sticky error, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | err_set;
    end
  end

  assign ITErr = err_q;
`endif

endmodule

// File: rtl/condlogic_it.sv
// Conditional-execution unit with IT-block predication.
// Optional sticky ITErr output enabled by defining CONDLOGIC_ITERR_EN.
module condlogic_it
  import condlogic_pkg::*;
#(
  parameter int unsigned IT_MAX = 4,
  parameter int unsigned LEN_W  = $clog2(IT_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              NextPC,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              InstrDone,
  input  logic              ITStart,
  input  logic [3:0]        ITCond,
  input  logic [IT_MAX-1:0] ITThen,
  input  logic [LEN_W-1:0]  ITLen,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic [3:0]        Flags,
  output logic              InITBlock,
  output logic [LEN_W-1:0]  ITRemaining
`ifdef CONDLOGIC_ITERR_EN
  ,
  output logic              ITErr
`endif
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_fl_q;
  logic [3:0] eff_cond;
  logic       cond_ex;
  logic [1:0] flag_write;

  it_tracker #(
    .IT_MAX (IT_MAX),
    .LEN_W  (LEN_W)
  ) u_it_tracker (
    .clk         (clk),
    .reset       (reset),
    .Cond        (Cond),
    .InstrDone   (InstrDone),
    .ITStart     (ITStart),
    .ITCond      (ITCond),
    .ITThen      (ITThen),
    .ITLen       (ITLen),
    .PCS         (PCS),
    .CondExFl    (cond_ex_fl_q),
    .EffCond     (eff_cond),
    .InITBlock   (InITBlock),
    .ITRemaining (ITRemaining)
`ifdef CONDLOGIC_ITERR_EN
    ,
    .ITErr       (ITErr)
`endif
  );

  condcheck u_condcheck (
    .Cond   (eff_cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  // Flag update is gated by the instruction's own (effective) condition.
  always_comb begin
    flag_write = FlagW & {2{cond_ex}};
    flags_d    = flags_q;
    if (flag_write[1]) begin
      flags_d[N] = ALUFlags[N];
      flags_d[Z] = ALUFlags[Z];
    end
    if (flag_write[0]) begin
      flags_d[C] = ALUFlags[C];
      flags_d[V] = ALUFlags[V];
    end
  end

  // Flags and the one-cycle-delayed condition result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q      <= '0;
      cond_ex_fl_q <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      cond_ex_fl_q <= cond_ex;
    end
  end

  // Write enables seen by the datapath.
  always_comb begin
    PCWrite  = NextPC | (PCS & cond_ex_fl_q);
    RegWrite = RegW & cond_ex_fl_q;
    MemWrite = MemW & cond_ex_fl_q;
  end

  assign Flags = flags_q;

endmodule

// File: tb/tb_condlogic_it.sv
// Directed self-checking bench for condlogic_it (IT_MAX=4).
// Also checks ITErr when built with CONDLOGIC_ITERR_EN.
module tb_condlogic_it;

  localparam int unsigned ItMax = 4;
  localparam int unsigned LenW  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       Cond, ALUFlags, ITCond;
  logic [1:0]       FlagW;
  logic             PCS, NextPC, RegW, MemW, InstrDone, ITStart;
  logic [ItMax-1:0] ITThen;
  logic [LenW-1:0]  ITLen;
  logic             PCWrite, RegWrite, MemWrite, InITBlock;
  logic [3:0]       Flags;
  logic [LenW-1:0]  ITRemaining;
`ifdef CONDLOGIC_ITERR_EN
  logic             ITErr;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  condlogic_it #(
    .IT_MAX (ItMax),
    .LEN_W  (LenW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagW       (FlagW),
    .PCS         (PCS),
    .NextPC      (NextPC),
    .RegW        (RegW),
    .MemW        (MemW),
    .InstrDone   (InstrDone),
    .ITStart     (ITStart),
    .ITCond      (ITCond),
    .ITThen      (ITThen),
    .ITLen       (ITLen),
    .PCWrite     (PCWrite),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .Flags       (Flags),
    .InITBlock   (InITBlock),
    .ITRemaining (ITRemaining)
`ifdef CONDLOGIC_ITERR_EN
    ,
    .ITErr       (ITErr)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-cycle instruction: evaluate cycle, then final cycle with InstrDone and write requests.
  task automatic instr(input logic pcs, input logic regw, input logic exp_rw, input logic exp_pw,
                       input string tag);
    InstrDone = 1'b0; RegW = 1'b0; PCS = 1'b0;
    tick();
    RegW = regw; PCS = pcs; InstrDone = 1'b1;
    #1;
    check({tag, "_regwrite"}, RegWrite, exp_rw);
    check({tag, "_pcwrite"}, PCWrite, exp_pw);
    tick();
    InstrDone = 1'b0; RegW = 1'b0; PCS = 1'b0;
  endtask

  task automatic it_start(input logic [3:0] c, input logic [ItMax-1:0] t, input logic [LenW-1:0] l);
    ITCond = c; ITThen = t; ITLen = l; ITStart = 1'b1; InstrDone = 1'b1;
    tick();
    ITStart = 1'b0; InstrDone = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; Cond = 4'b1110; ALUFlags = '0; FlagW = '0; PCS = 1'b0; NextPC = 1'b0;
    RegW = 1'b0; MemW = 1'b0; InstrDone = 1'b0; ITStart = 1'b0; ITCond = '0; ITThen = '0;
    ITLen = '0;
    #12;
    check("rst_flags", Flags, 8'h0);
    check("rst_init", InITBlock, 8'h0);
    check("rst_rem", ITRemaining, 8'h0);
    check("rst_regwrite", RegWrite, 8'h0);
    check("rst_memwrite", MemWrite, 8'h0);
    check("rst_pcwrite", PCWrite, 8'h0);
    NextPC = 1'b1;
    #1;
    check("rst_pcwrite_nextpc", PCWrite, 8'h1);
    NextPC = 1'b0;
`ifdef CONDLOGIC_ITERR_EN
    check("rst_iterr", ITErr, 8'h0);
`endif
    reset = 1'b0;
    tick();

    // Load Z,C,V set.
    FlagW = 2'b11; Cond = 4'b1110; ALUFlags = 4'b0111;
    tick();
    FlagW = 2'b00;
    check("flags_load", Flags, 8'h7);
    Cond = 4'b0001;  // NE false, clears CondExFl
    tick();
    Cond = 4'b0000; RegW = 1'b1; MemW = 1'b1;
    #1;
    check("eq_latency", RegWrite, 8'h0);
    tick();
    check("eq_regwrite", RegWrite, 8'h1);
    check("eq_memwrite", MemWrite, 8'h1);
    Cond = 4'b0001;
    tick();
    check("ne_regwrite", RegWrite, 8'h0);
    RegW = 1'b0; MemW = 1'b0;

    // Partial flag write: N,Z only.
    FlagW = 2'b10; Cond = 4'b1110; ALUFlags = 4'b1010;
    tick();
    check("flags_nz_only", Flags, 8'hb);
    FlagW = 2'b11; Cond = 4'b0000; ALUFlags = 4'b0100;  // EQ false now
    tick();
    check("flags_cond_false", Flags, 8'hb);
    Cond = 4'b1110;
    tick();
    FlagW = 2'b00;
    check("flags_z", Flags, 8'h4);

    // IT EQ, then/else/then, length 3; own Cond is AL throughout.
    it_start(4'b0000, 4'b0101, 3'd3);
    check("it_active", InITBlock, 8'h1);
    check("it_rem3", ITRemaining, 8'h3);
    instr(1'b0, 1'b1, 1'b1, 1'b0, "it_slot0");
    check("it_rem2", ITRemaining, 8'h2);
    instr(1'b0, 1'b1, 1'b0, 1'b0, "it_slot1");
    check("it_rem1", ITRemaining, 8'h1);
    instr(1'b0, 1'b1, 1'b1, 1'b0, "it_slot2");
    check("it_rem0", ITRemaining, 8'h0);
    check("it_done", InITBlock, 8'h0);

    // Taken branch in slot 1 of a length-4 block.
    it_start(4'b0000, 4'b1111, 3'd4);
    check("br_rem4", ITRemaining, 8'h4);
    instr(1'b0, 1'b1, 1'b1, 1'b0, "br_slot0");
    check("br_rem3", ITRemaining, 8'h3);
    instr(1'b1, 1'b0, 1'b0, 1'b1, "br_slot1");
    check("br_abort_init", InITBlock, 8'h0);
    check("br_abort_rem", ITRemaining, 8'h0);
    Cond = 4'b0001;  // own condition NE is false with Z=1
    instr(1'b0, 1'b1, 1'b0, 1'b0, "post_br");
    Cond = 4'b1110;

    // Invalid starts.
    it_start(4'b0000, 4'b1111, 3'd0);
    check("len0_idle", InITBlock, 8'h0);
`ifdef CONDLOGIC_ITERR_EN
    check("len0_iterr", ITErr, 8'h1);
`endif
    it_start(4'b0000, 4'b1111, 3'd5);
    check("len5_idle", InITBlock, 8'h0);
    ITStart = 1'b1; ITLen = 3'd2;
    tick();
    ITStart = 1'b0;
    check("nodone_idle", InITBlock, 8'h0);

    // Asynchronous reset mid-block.
    it_start(4'b0000, 4'b0101, 3'd3);
    instr(1'b0, 1'b1, 1'b1, 1'b0, "rst_slot0");
    check("rst_mid_rem2", ITRemaining, 8'h2);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_flags", Flags, 8'h0);
    check("rst_mid_init", InITBlock, 8'h0);
    check("rst_mid_rem", ITRemaining, 8'h0);
`ifdef CONDLOGIC_ITERR_EN
    check("rst_mid_iterr", ITErr, 8'h0);
`endif
    tick();
    reset = 1'b0;
    tick();

    // AL base with an else slot still executes.
    it_start(4'b1110, 4'b0000, 3'd1);
    check("al_active", InITBlock, 8'h1);
    instr(1'b0, 1'b1, 1'b1, 1'b0, "al_else");
    check("al_done", InITBlock, 8'h0);
`ifdef CONDLOGIC_ITERR_EN
    check("al_iterr", ITErr, 8'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
